// File: rtl/fpdiv.sv
// rtl/fpdiv.sv - binary16 divider: unpack, 14-step restoring divide, RNE round
module fpdiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_res,
  output logic        o_valid,
  output logic        o_busy,
  output logic        overflow,
  output logic        o_div_zero
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_DIVIDE = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]         r_state;
  logic [15:0]        r_a;
  logic [15:0]        r_b;
  logic [10:0]        r_mb;
  logic [11:0]        r_rem;
  logic [13:0]        r_q;
  logic [3:0]         r_cnt;
  logic signed [6:0]  r_exp;

  logic [4:0]         w_ea, w_eb;
  logic [9:0]         w_fa, w_fb;
  logic               w_sign;
  logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic               w_special;
  logic [15:0]        w_spec_res;
  logic               w_spec_dz;
  logic               w_ge;
  logic [11:0]        w_rem_sub;
  logic [10:0]        w_mant;
  logic               w_guard, w_sticky, w_inc;
  logic signed [6:0]  w_e0, w_e1;
  logic [11:0]        w_sum;
  logic [10:0]        w_mant_r;
  logic [15:0]        w_rnd_res;
  logic               w_ovf;

  assign w_ea   = r_a[14:10];
  assign w_eb   = r_b[14:10];
  assign w_fa   = r_a[9:0];
  assign w_fb   = r_b[9:0];
  assign w_sign = r_a[15] ^ r_b[15];

  assign w_a_zero = (w_ea == 5'd0);
  assign w_b_zero = (w_eb == 5'd0);
  assign w_a_inf  = (w_ea == 5'd31) && (w_fa == 10'd0);
  assign w_b_inf  = (w_eb == 5'd31) && (w_fb == 10'd0);
  assign w_a_nan  = (w_ea == 5'd31) && (w_fa != 10'd0);
  assign w_b_nan  = (w_eb == 5'd31) && (w_fb != 10'd0);

  assign o_busy  = (r_state == S_UNPACK) || (r_state == S_DIVIDE) || (r_state == S_ROUND);
  assign o_valid = (r_state == S_DONE);

  // Special-operand decode in priority order; subnormals already count as zero
  always_comb begin
    w_special  = 1'b1;
    w_spec_res = 16'h7E00;
    w_spec_dz  = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res = 16'h7E00;
    end else if (w_a_inf) begin
      w_spec_res = {w_sign, 5'h1F, 10'h000};
    end else if (w_b_inf || w_a_zero) begin
      w_spec_res = {w_sign, 15'h0000};
    end else if (w_b_zero) begin
      w_spec_res = {w_sign, 5'h1F, 10'h000};
      w_spec_dz  = 1'b1;
    end else begin
      w_special  = 1'b0;
    end
  end

  // One restoring-division step: trial subtract of the divisor from the remainder
  always_comb begin
    w_ge      = (r_rem >= {1'b0, r_mb});
    w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  end

  // Normalise the 14-bit quotient, round to nearest even, then range-check the exponent
  always_comb begin
    if (r_q[13]) begin
      w_mant   = r_q[13:3];
      w_guard  = r_q[2];
      w_sticky = (|r_q[1:0]) | (|r_rem);
      w_e0     = r_exp;
    end else begin
      w_mant   = r_q[12:2];
      w_guard  = r_q[1];
      w_sticky = r_q[0] | (|r_rem);
      w_e0     = r_exp - 7'sd1;
    end
    w_inc = w_guard & (w_sticky | w_mant[0]);
    w_sum = {1'b0, w_mant} + {11'd0, w_inc};
    if (w_sum[11]) begin
      w_mant_r = w_sum[11:1];
      w_e1     = w_e0 + 7'sd1;
    end else begin
      w_mant_r = w_sum[10:0];
      w_e1     = w_e0;
    end
    w_ovf = 1'b0;
    if (w_e1 >= 7'sd31) begin
      w_rnd_res = {w_sign, 5'h1F, 10'h000};
      w_ovf     = 1'b1;
    end else if (w_e1 <= 7'sd0) begin
      w_rnd_res = {w_sign, 15'h0000};
    end else begin
      w_rnd_res = {w_sign, w_e1[4:0], w_mant_r[9:0]};
    end
  end

  // Control FSM plus datapath registers; results and flags load on entry to DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_a        <= 16'd0;
      r_b        <= 16'd0;
      r_mb       <= 11'd0;
      r_rem      <= 12'd0;
      r_q        <= 14'd0;
      r_cnt      <= 4'd0;
      r_exp      <= 7'sd0;
      o_res      <= 16'd0;
      overflow   <= 1'b0;
      o_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_state <= S_UNPACK;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_UNPACK: begin
          if (w_special) begin
            o_res      <= w_spec_res;
            overflow   <= 1'b0;
            o_div_zero <= w_spec_dz;
            r_state    <= S_DONE;
          end else begin
            r_rem   <= {2'b01, w_fa};
            r_mb    <= {1'b1, w_fb};
            r_exp   <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 7'sd15;
            r_q     <= 14'd0;
            r_cnt   <= 4'd0;
            r_state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          r_q   <= {r_q[12:0], w_ge};
          r_rem <= {w_rem_sub[10:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd13) r_state <= S_ROUND;
        end
        S_ROUND: begin
          o_res      <= w_rnd_res;
          overflow   <= w_ovf;
          o_div_zero <= 1'b0;
          r_state    <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv.sv
// tb/tb_fpdiv.sv - directed self-checking bench for fpdiv
module tb_fpdiv;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic [15:0] o_res;
  logic        o_valid;
  logic        o_busy;
  logic        overflow;
  logic        o_div_zero;

  int checks = 0;
  int errors = 0;
  int lat;
  int b1;
  int nvalid;

  fpdiv dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_res      (o_res),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .overflow   (overflow),
    .o_div_zero (o_div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; the posedge inside is T0, inputs are scrambled afterwards
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    i_start = 1'b1;
    i_a     = a;
    i_b     = b;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_a     = 16'hA5A5;
    i_b     = 16'h5A5A;
  endtask

  // Counts negedges after T0; n means o_valid is sampled by edge T0+n
  task automatic wait_valid(output int n, output int busy1);
    n = 0;
    busy1 = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) busy1 = int'(o_busy);
    end while (!o_valid && n < 40);
  endtask

  task automatic check_result(input string tag, input logic [15:0] res, input logic ovf,
                              input logic dz, input int exp_lat);
    wait_valid(lat, b1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy"}, b1, 1);
    chk({tag, " res"}, o_res, res);
    chk({tag, " overflow"}, overflow, ovf);
    chk({tag, " div_zero"}, o_div_zero, dz);
    chk({tag, " busy_done"}, o_busy, 0);
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] res, input logic ovf, input logic dz, input int exp_lat);
    launch(a, b);
    check_result(tag, res, ovf, dz, exp_lat);
    @(negedge clk);
    chk({tag, " valid_pulse"}, o_valid, 0);
  endtask

  initial begin
    rst = 1'b0;
    i_start = 1'b0;
    i_a = 16'h0;
    i_b = 16'h0;
    @(negedge clk);
    @(negedge clk);
    chk("reset res", o_res, 16'h0000);
    chk("reset valid", o_valid, 0);
    chk("reset busy", o_busy, 0);
    chk("reset ovf", overflow, 0);
    chk("reset dz", o_div_zero, 0);
    rst = 1'b1;
    @(negedge clk);

    op("2/1",       16'h4000, 16'h3C00, 16'h4000, 1'b0, 1'b0, 17);
    op("1/3",       16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0, 17);
    op("-5/2",      16'hC500, 16'h4000, 16'hC100, 1'b0, 1'b0, 17);
    op("1.25/1.125",16'h3D00, 16'h3C80, 16'h3C72, 1'b0, 1'b0, 17);
    op("1/0",       16'h3C00, 16'h0000, 16'h7C00, 1'b0, 1'b1, 2);
    op("0/0",       16'h0000, 16'h0000, 16'h7E00, 1'b0, 1'b0, 2);
    op("max/min",   16'h7BFF, 16'h0400, 16'h7C00, 1'b1, 1'b0, 17);
    op("min/max",   16'h0400, 16'h7BFF, 16'h0000, 1'b0, 1'b0, 17);
    op("inf/2",     16'h7C00, 16'h4000, 16'h7C00, 1'b0, 1'b0, 2);
    op("2/-inf",    16'h4000, 16'hFC00, 16'h8000, 1'b0, 1'b0, 2);
    op("nan/1",     16'h7C01, 16'h3C00, 16'h7E00, 1'b0, 1'b0, 2);
    op("inf/-inf",  16'h7C00, 16'hFC00, 16'h7E00, 1'b0, 1'b0, 2);
    op("sub/1",     16'h0001, 16'h3C00, 16'h0000, 1'b0, 1'b0, 2);
    op("-0/1",      16'h8000, 16'h3C00, 16'h8000, 1'b0, 1'b0, 2);
    op("1/-sub",    16'h3C00, 16'h8001, 16'hFC00, 1'b0, 1'b1, 2);

    // Start pulse while busy must be ignored
    launch(16'h4000, 16'h3C00);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin
        i_start = 1'b1;
        i_a = 16'h3C00;
        i_b = 16'h0000;
      end else begin
        i_start = 1'b0;
      end
    end while (!o_valid && lat < 40);
    chk("busy_start latency", lat, 17);
    chk("busy_start res", o_res, 16'h4000);
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_valid) nvalid++;
    end
    chk("busy_start no_extra_valid", nvalid, 0);

    // Back-to-back: new start issued during the DONE cycle
    launch(16'h3C00, 16'h4200);
    check_result("b2b first", 16'h3555, 1'b0, 1'b0, 17);
    launch(16'hC500, 16'h4000);
    check_result("b2b second", 16'hC100, 1'b0, 1'b0, 17);
    @(negedge clk);

    // Reset between T0+8 and T0+9 aborts the operation
    launch(16'h3C00, 16'h4200);
    for (int i = 0; i < 8; i++) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort res", o_res, 16'h0000);
    chk("abort busy", o_busy, 0);
    chk("abort valid", o_valid, 0);
    chk("abort ovf", overflow, 0);
    chk("abort dz", o_div_zero, 0);
    @(negedge clk);
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_valid) nvalid++;
    end
    chk("abort no_valid", nvalid, 0);
    rst = 1'b1;
    launch(16'h3D00, 16'h3C80);
    check_result("after_reset", 16'h3C72, 1'b0, 1'b0, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpdiv.md
FPDIV -- requirements
Module: fpdiv

Interface
REQ-001 Parameters: none; format fixed to IEEE-754 binary16: 1 sign bit, 5 exponent bits, 10 fraction bits, bias 15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-004 i_start  input  1  request; sampled only when o_busy=0.
REQ-005 i_a  input  16  dividend, binary16.
REQ-006 i_b  input  16  divisor, binary16.
REQ-007 o_res  output  16  quotient, binary16; holds the last result until the next o_valid.
REQ-008 o_valid  output  1  one-cycle pulse marking o_res/flags as new.
REQ-009 o_busy  output  1  operation in progress; i_start ignored while high.
REQ-010 overflow  output  1  finite result rounded to infinity; updated with each o_valid.
REQ-011 o_div_zero  output  1  finite nonzero dividend divided by zero; updated with each o_valid.

Function
REQ-012 Define edge T0 as the edge sampling i_start=1 with o_busy=0. At T0, i_a and i_b are captured; later input changes have no effect.
REQ-013 FSM states: IDLE, UNPACK, DIVIDE, ROUND, DONE. IDLE->UNPACK at T0; UNPACK->DIVIDE (normal) or ->DONE (special); DIVIDE holds for 14 cycles then ->ROUND; ROUND->DONE; DONE->IDLE, or ->UNPACK if i_start=1 in the DONE cycle.
REQ-014 o_busy=1 from T0+1 until DONE is entered; o_busy=0 and o_valid=1 in the DONE cycle only, so back-to-back starts are accepted.
REQ-015 Latency: normal operands give o_valid after edge T0+17; special cases give o_valid after edge T0+2.
REQ-016 Exponent 0 operands (zero/subnormal) are treated as signed zero; subnormal results flush to signed zero.
REQ-017 Sign of every non-NaN result = sign(i_a) XOR sign(i_b). NaN output is always 0x7E00.
REQ-018 Special priority: any NaN input, 0/0, or inf/inf -> 0x7E00; inf/x -> signed inf; x/inf -> signed zero; 0/x -> signed zero; finite nonzero/0 -> signed inf with o_div_zero=1.
REQ-019 Normal path: Ma={1,frac_a}, Mb={1,frac_b} (11 bits); exponent E = Ea - Eb + 15, held as 7-bit signed.
REQ-020 DIVIDE: restoring division. Remainder starts at Ma. Each cycle: if rem>=Mb then q bit=1 and rem-=Mb, else q bit=0; then rem<<=1. Bits fill q[13] down to q[0] (q[13] is the integer bit).
REQ-021 ROUND stage, q[13]=1: mantissa=q[13:3], guard=q[2], sticky=|q[1:0] or rem!=0.
REQ-022 ROUND stage, q[13]=0: mantissa=q[12:2], guard=q[1], sticky=q[0] or rem!=0, and E-=1.
REQ-023 Rounding: round-to-nearest-even; increment when guard=1 and (sticky=1 or mantissa[0]=1); a carry out of bit 10 shifts the mantissa right and sets E+=1.
REQ-024 After rounding: E>=31 -> signed inf with overflow=1; E<=0 -> signed zero; otherwise o_res={sign, E[4:0], mantissa[9:0]}.
REQ-025 Flags not asserted for a result are cleared at that result's o_valid.

Reset
REQ-026 While rst=0: state=IDLE, o_res=0x0000, o_valid=0, o_busy=0, overflow=0, o_div_zero=0, internal quotient/remainder cleared.
REQ-027 Reset mid-operation aborts it with no o_valid. The first edge with rst=1 and i_start=1 is a valid T0.

Verification
REQ-028 i_a=0x4000, i_b=0x3C00 -> o_res=0x4000, o_valid after edge T0+17, flags 0.
REQ-029 i_a=0x3C00, i_b=0x4200 -> o_res=0x3555 (round-down case). i_a=0xC500, i_b=0x4000 -> o_res=0xC100.
REQ-030 i_a=0x3C00, i_b=0x0000 -> o_res=0x7C00, o_div_zero=1, o_valid after T0+2. i_a=0x0000, i_b=0x0000 -> 0x7E00, o_div_zero=0.
REQ-031 i_a=0x7BFF, i_b=0x0400 -> o_res=0x7C00, overflow=1. i_a=0x0400, i_b=0x7BFF -> o_res=0x0000.
REQ-032 i_start pulsed at T0+5 -> ignored, single o_valid at T0+17. New start in the DONE cycle -> next o_valid at that edge +17.
REQ-033 rst=0 asserted between T0+8 and T0+9 -> all outputs 0 immediately, no o_valid. Start after release -> correct result after 17 edges.
